// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline-stage registers of the RISC-V core.
//   pipe_state_t   : occupancy of a skid stage (debug and assertions)
//   *_DATA_W/_CTRL_W : default bundle widths for each stage boundary
//   pipe_state_of  : maps the two slot valid bits onto pipe_state_t
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    localparam int IFID_DATA_W  = 64;
    localparam int IFID_CTRL_W  = 4;
    localparam int IDEX_DATA_W  = 128;
    localparam int IDEX_CTRL_W  = 16;
    localparam int EXMEM_DATA_W = 112;
    localparam int EXMEM_CTRL_W = 8;
    localparam int MEMWB_DATA_W = 72;
    localparam int MEMWB_CTRL_W = 4;

    // The skid slot is only ever filled while main is valid, so a valid skid
    // alone is reported as TWO rather than given its own encoding.
    function automatic pipe_state_t pipe_state_of(input logic main_valid,
                                                  input logic skid_valid);
        if (skid_valid)
            return PS_TWO;
        else if (main_valid)
            return PS_ONE;
        else
            return PS_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
// One {valid, data, ctrl} storage entry of a pipeline stage.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   load         : capture load_data/load_ctrl and mark the entry valid
//   clear        : invalidate and zero the entry (wins over load)
//   valid/data/ctrl : registered entry contents
// An invalid entry always holds zero in data and ctrl.
// ---------------------------------------------------------------------------
module pipe_slot #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Clear zeroes the payload as well as the valid bit so that an empty slot
    // can drive the stage outputs directly without any side effects.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            ctrl  <= load_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// Pipeline-stage register with valid/ready handshake and a two-entry skid
// buffer (main + skid).
//   CLK, RESET_N        : clock, asynchronous active-low reset
//   FLUSH               : synchronous squash of both entries, top priority
//   in_valid/in_ready   : upstream handshake (in_ready from flops only)
//   in_data/in_ctrl     : upstream bundles
//   out_valid/out_ready : downstream handshake
//   out_data/out_ctrl   : head entry bundles, zero when out_valid=0
// All outputs come straight from slot flops.
// ---------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = IDEX_DATA_W,
    parameter int CTRL_W = IDEX_CTRL_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              FLUSH,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

    logic              main_load, main_clear, main_from_skid;
    logic              skid_load, skid_clear;
    logic [DATA_W-1:0] main_load_data;
    logic [CTRL_W-1:0] main_load_ctrl;

    logic              accept, drain;
    pipe_state_t       state;

    assign state     = pipe_state_of(main_valid, skid_valid);
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign accept    = in_valid && in_ready;
    assign drain     = main_valid && out_ready;

    // Transition logic: decides which slot loads or clears this edge. The
    // skid is only written when main is valid and stalled, so it never holds
    // an older instruction than main and FIFO order is preserved.
    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (FLUSH) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                PS_EMPTY: begin
                    main_load = accept;
                end
                PS_ONE: begin
                    if (accept && drain)
                        main_load = 1'b1;
                    else if (accept)
                        skid_load = 1'b1;
                    else if (drain)
                        main_clear = 1'b1;
                end
                PS_TWO: begin
                    if (drain) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign main_load_data = main_from_skid ? skid_data : in_data;
    assign main_load_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .load      (main_load),
        .clear     (main_clear),
        .load_data (main_load_data),
        .load_ctrl (main_load_ctrl),
        .valid     (main_valid),
        .data      (main_data),
        .ctrl      (main_ctrl)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (in_data),
        .load_ctrl (in_ctrl),
        .valid     (skid_valid),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
    );

    // A valid skid behind an empty main would break ordering.
    skid_implies_main: assert property (@(posedge CLK) disable iff (!RESET_N)
                                        skid_valid |-> main_valid);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
// Self-checking bench for pipe_stage_skid: directed scenarios with literal
// expectations, then randomized valid/ready/flush traffic compared every
// cycle against a queue model of a two-deep FIFO.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int DW = 128;
    localparam int CW = 16;

    logic          CLK;
    logic          RESET_N;
    logic          FLUSH;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } item_t;

    item_t model_q[$];

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .FLUSH     (FLUSH),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
    );

    // 10-unit clock: rising edges at 5, 15, ...; falling edges at 10, 20, ...
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                                 input logic [CW-1:0] c, input logic r,
                                 input logic f);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        FLUSH     = f;
    endtask

    // Drive inputs for one rising edge and return at the following falling
    // edge, where the outputs reflect that edge.
    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input logic r, input logic f);
        applyStimulus(v, d, c, r, f);
        @(negedge CLK);
    endtask

    // Reference model: a FIFO of capacity two. Ready means "room left";
    // flush empties it; a drain frees room for a same-edge accept.
    always @(posedge CLK or negedge RESET_N) begin
        bit acc, drn;
        if (!RESET_N) begin
            model_q.delete();
        end else if (FLUSH) begin
            model_q.delete();
        end else begin
            acc = in_valid && (model_q.size() < 2);
            drn = (model_q.size() > 0) && out_ready;
            if (drn)
                void'(model_q.pop_front());
            if (acc)
                model_q.push_back('{d: in_data, c: in_ctrl});
        end
    end

    // Compare process: outputs against the model on every falling edge.
    always @(negedge CLK) begin
        logic [DW-1:0] exp_d;
        logic [CW-1:0] exp_c;
        if (check_en) begin
            exp_d = '0;
            exp_c = '0;
            if (model_q.size() > 0) begin
                exp_d = model_q[0].d;
                exp_c = model_q[0].c;
            end
            checkOutput("cmp_out_valid", DW'(out_valid), DW'(model_q.size() > 0));
            checkOutput("cmp_in_ready", DW'(in_ready), DW'(model_q.size() < 2));
            checkOutput("cmp_out_data", out_data, exp_d);
            checkOutput("cmp_out_ctrl", DW'(out_ctrl), DW'(exp_c));
        end
    end

    initial begin
        RESET_N = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);
        checkOutput("reset_out_valid", DW'(out_valid), DW'(0));
        checkOutput("reset_out_data", out_data, DW'(0));
        checkOutput("reset_out_ctrl", DW'(out_ctrl), DW'(0));
        checkOutput("reset_in_ready", DW'(in_ready), DW'(1));
        RESET_N  = 1'b1;
        check_en = 1'b1;

        // Streaming 1..4 at full rate, one cycle of latency.
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, DW'(i), CW'(16'h0010 + i), 1'b1, 1'b0);
            checkOutput("stream_valid", DW'(out_valid), DW'(1));
            checkOutput("stream_data", out_data, DW'(i));
            checkOutput("stream_ctrl", DW'(out_ctrl), DW'(16'h0010 + i));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("stream_drained", DW'(out_valid), DW'(0));

        // Back-pressure: item 2 lands in skid while out_ready is low.
        step(1'b1, DW'(1), CW'(1), 1'b1, 1'b0);
        checkOutput("bp_head1", out_data, DW'(1));
        step(1'b1, DW'(2), CW'(2), 1'b0, 1'b0);
        checkOutput("bp_two_ready", DW'(in_ready), DW'(0));
        checkOutput("bp_hold1a", out_data, DW'(1));
        step(1'b1, DW'(3), CW'(3), 1'b0, 1'b0);
        checkOutput("bp_hold1b", out_data, DW'(1));
        step(1'b1, DW'(3), CW'(3), 1'b0, 1'b0);
        checkOutput("bp_hold1c", out_data, DW'(1));
        step(1'b1, DW'(3), CW'(3), 1'b1, 1'b0);
        checkOutput("bp_head2", out_data, DW'(2));
        checkOutput("bp_ready_back", DW'(in_ready), DW'(1));
        step(1'b1, DW'(3), CW'(3), 1'b1, 1'b0);
        checkOutput("bp_head3", out_data, DW'(3));
        step(1'b1, DW'(4), CW'(4), 1'b1, 1'b0);
        checkOutput("bp_head4", out_data, DW'(4));
        step(1'b1, DW'(5), CW'(5), 1'b1, 1'b0);
        checkOutput("bp_head5", out_data, DW'(5));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("bp_empty", DW'(out_valid), DW'(0));

        // Flush in TWO with a new item presented; then flush in ONE.
        step(1'b1, DW'(7), CW'(7), 1'b0, 1'b0);
        step(1'b1, DW'(8), CW'(8), 1'b0, 1'b0);
        checkOutput("fl_two", DW'(in_ready), DW'(0));
        step(1'b1, DW'(9), CW'(9), 1'b0, 1'b1);
        checkOutput("fl_valid", DW'(out_valid), DW'(0));
        checkOutput("fl_data", out_data, DW'(0));
        checkOutput("fl_ctrl", DW'(out_ctrl), DW'(0));
        checkOutput("fl_ready", DW'(in_ready), DW'(1));
        step(1'b1, DW'(7), CW'(7), 1'b0, 1'b0);
        step(1'b1, DW'(9), CW'(9), 1'b1, 1'b1);
        checkOutput("fl_one_valid", DW'(out_valid), DW'(0));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("fl_no_ghost", DW'(out_valid), DW'(0));

        // Bubbles carrying a noisy control bundle.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b1, 1'b0);
            checkOutput("bubble_valid", DW'(out_valid), DW'(0));
            checkOutput("bubble_ctrl", DW'(out_ctrl), DW'(0));
        end

        // Asynchronous reset pulse between edges while in TWO.
        step(1'b1, DW'(32'hA), CW'(16'h00AA), 1'b0, 1'b0);
        step(1'b1, DW'(32'hB), CW'(16'h00BB), 1'b0, 1'b0);
        checkOutput("rst_pre_two", DW'(in_ready), DW'(0));
        checkOutput("rst_pre_head", out_data, DW'(32'hA));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        #2 RESET_N = 1'b0;
        #1;
        checkOutput("rst_mid_valid", DW'(out_valid), DW'(0));
        checkOutput("rst_mid_data", out_data, DW'(0));
        checkOutput("rst_mid_ctrl", DW'(out_ctrl), DW'(0));
        checkOutput("rst_mid_ready", DW'(in_ready), DW'(1));
        #1 RESET_N = 1'b1;
        step(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("rst_no_ghost", DW'(out_valid), DW'(0));

        // Random traffic; the compare process checks every cycle.
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 9) < 7,
                 {$urandom, $urandom, $urandom, $urandom},
                 CW'($urandom),
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) < 3);
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register for the RISC-V core. It carries an opaque data bundle and a control bundle between two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) using a valid/ready handshake with a two-entry skid buffer. Synchronous flush inserts a bubble, and the control bundle is forced to zero whenever the stage holds no valid instruction. It replaces the fixed-field stage registers, so every stage boundary gets stall, flush and back-pressure without a combinational ready path.

## Interface
- DATA_W, 128: width of the data bundle (PC, immediates, operands, register indices).
- CTRL_W, 16: width of the control bundle (RegWrite, MemWrite, Branch, ...); zero means "no side effects".
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- FLUSH  in  1  synchronous squash of all held entries; has priority over every other input.
- in_valid  in  1  upstream stage presents an instruction.
- in_ready  out  1  stage can accept; depends only on internal state.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  stage holds a valid instruction for downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  data bundle of the head entry.
- out_ctrl  out  CTRL_W  control bundle of the head entry; all-zero when out_valid=0.

## Operation
- Storage: main entry (drives outputs) and skid entry, each {valid, data, ctrl}.
- State is derived from the valid bits:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - TWO: both valid.
- in_ready = !skid.valid, so it is 1 in EMPTY and ONE and 0 in TWO.
- Accept: in_valid & in_ready. Drain: out_valid & out_ready.
- Transitions (FLUSH=0):
  - EMPTY, accept: main<=in → ONE.
  - ONE, accept & drain: main<=in → ONE.
  - ONE, accept & !drain: skid<=in → TWO.
  - ONE, !accept & drain → EMPTY; main cleared.
  - ONE, neither: hold.
  - TWO, drain: main<=skid, skid cleared → ONE.
  - TWO, !drain: hold. No accept is possible in TWO.
- FLUSH=1: both entries cleared (valid, data, ctrl = 0) → EMPTY. A same-cycle accept or drain is discarded, so downstream must not commit an instruction it sees in a flush cycle; the hazard unit guarantees this.
- Every cleared or invalid entry stores zero in data and ctrl. out_data and out_ctrl are therefore 0 whenever out_valid=0.
- An entry is never overwritten while it is valid and not drained.

## Timing
- Reset (RESET_N low, asynchronous): both entries invalid and zero. out_valid=0, out_data=0, out_ctrl=0, in_ready=1.
- Release of reset is synchronous to CLK; the first accept is possible on the first edge after release.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N.
- Throughput: one instruction per cycle while out_ready=1.
- No combinational path from out_ready to in_ready, or from in_* to out_*; all outputs come from flops.
- After a single out_ready=0 cycle with in_valid=1, in_ready falls on the next cycle. It rises one cycle after the drain from TWO.
- Ordering is strict FIFO; skid contents never bypass main.

## Structure
- Shared package pipe_pkg:
  - typedef enum {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_t, used for debug and assertions.
  - Default widths for each stage boundary: IFID_DATA_W, IDEX_DATA_W, IDEX_CTRL_W, and so on.
- Sub-module pipe_slot: one {valid, data, ctrl} register with load, clear and asynchronous reset. It is instantiated twice (main and skid).
- The top level contains only the transition logic.

## Test plan
- Reset mid-stream: fill to TWO with data 0xA/0xB, then pulse RESET_N low between edges → outputs immediately zero, in_ready=1, and no ghost output after release.
- Streaming: in_valid=1 with in_data=1,2,3,4 and out_ready=1 → out_data=1,2,3,4 on consecutive cycles, one cycle later than input, with out_valid held at 1.
- Back-pressure: stream 1..5 with out_ready=0 for 3 cycles starting at the cycle item 2 arrives → in_ready=0 while in TWO, and out_data shows 1..5 in order with no loss or duplication.
- Flush priority: state TWO (items 7, 8) with FLUSH=1 and in_valid=1 (item 9) in the same cycle → next cycle out_valid=0, out_ctrl=0, out_data=0, in_ready=1, and item 9 is never output.
- Bubble control: in_valid=0 with in_ctrl=16'hFFFF → out_ctrl stays 0 and out_valid=0 every cycle.
- Random ready/valid plus FLUSH for 10k cycles against a queue model → order and contents match, out_ctrl=0 whenever !out_valid, and in_ready is never 1 in TWO.
